// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // EX/MEM MEM-field layout: MemRead at bit 1, MemWrite at bit 0
    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctl_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge bus between the access controller and data memory.
interface dmem_access_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl_timeout_cnt.sv
// Wait counter for an outstanding memory request; expires at TIMEOUT_CYC-1.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [CNT_W-1:0] cnt_q;

    // Count cycles spent waiting; clear has priority over enable
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage responder: turns single-cycle load/store requests into a
// req/ack handshake, stalls the pipeline while waiting, flags bad accesses.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  stall_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  err_o,
    dmem_access_ctrl_if.master    mem_bus
);
    state_t            state_q, state_d;
    mem_ctl_t          mem_ctl;
    logic              aligned, any_req, legal_req, illegal_req;
    logic              issue, err_d, cnt_clr, cnt_en, expire;
    logic              req_q, we_q;
    logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;

    assign mem_ctl     = '{mem_read: MemRead_i, mem_write: MemWrite_i};
    assign aligned     = ((addr_i[1:0] & WORD_ALIGN_MASK) == 2'b00);
    assign any_req     = mem_ctl.mem_read | mem_ctl.mem_write;
    assign legal_req   = (mem_ctl.mem_read ^ mem_ctl.mem_write) & aligned;
    assign illegal_req = (mem_ctl.mem_read & mem_ctl.mem_write) | (any_req & ~aligned);

    dmem_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expire_o (expire)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, stall and control decode
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        issue   = 1'b0;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (legal_req) begin
                    stall_o = 1'b1;
                    issue   = 1'b1;
                    state_d = REQ;
                end else if (illegal_req) begin
                    // Bad access still retires once via DONE, without stalling
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem_bus.mem_ack_i) begin
                    state_d = DONE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus registers, load-data capture and error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= err_d;
            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= MemWrite_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end else if (state_q == REQ && (mem_bus.mem_ack_i || expire)) begin
                req_q <= 1'b0;
            end
            if (state_q == REQ && mem_bus.mem_ack_i && !we_q) begin
                rdata_q <= mem_bus.mem_rdata_i;
            end
        end
    end

    assign mem_bus.mem_req_o   = req_q;
    assign mem_bus.mem_we_o    = we_q;
    assign mem_bus.mem_addr_o  = addr_q;
    assign mem_bus.mem_wdata_o = wdata_q;
    assign rdata_o             = rdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [DATA_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              err;

    int errors = 0;
    int checks = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;
    int stalls, reqs, rises0;

    dmem_access_ctrl_if #(.DATA_W(DATA_W)) mem_bus ();

    dmem_access_ctrl #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (mem_read),
        .MemWrite_i (mem_write),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .stall_o    (stall),
        .rdata_o    (rdata),
        .err_o      (err),
        .mem_bus    (mem_bus.master)
    );

    always #5 clk = ~clk;

    // Count request launches to catch duplicates
    always @(posedge clk) begin
        if (mem_bus.mem_req_o && !req_prev) req_rises++;
        req_prev <= mem_bus.mem_req_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one access from its IDLE cycle; ack in REQ cycle k (k=0: never)
    task automatic run_access(input int k, input logic [31:0] rd,
                              output int n_stall, output int n_req);
        n_stall = 0;
        n_req   = 0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (!stall) break;
            n_stall++;
            if (mem_bus.mem_req_o) n_req++;
            mem_bus.mem_ack_i   = (k > 0 && n_req == k && mem_bus.mem_req_o);
            mem_bus.mem_rdata_i = rd;
            @(posedge clk);
            #1;
            mem_bus.mem_ack_i   = 1'b0;
            mem_bus.mem_rdata_i = 32'h0BAD_0BAD;
            #1;
        end
        if (stall) check_eq("stall_bound", 32'(stall), 32'd0);
    endtask

    initial begin
        mem_bus.mem_ack_i   = 1'b0;
        mem_bus.mem_rdata_i = '0;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_req",   32'(mem_bus.mem_req_o), 32'd0);
        check_eq("rst_we",    32'(mem_bus.mem_we_o), 32'd0);
        check_eq("rst_addr",  mem_bus.mem_addr_o, 32'h0);
        check_eq("rst_wdata", mem_bus.mem_wdata_o, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_err",   32'(err), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);

        // Load, ack in 3rd REQ cycle
        tick();
        mem_read = 1'b1;
        addr     = 32'h100;
        run_access(3, 32'hCAFEF00D, stalls, reqs);
        check_eq("ld_stall_cyc", stalls, 4);
        check_eq("ld_req_cyc",   reqs, 3);
        check_eq("ld_addr",      mem_bus.mem_addr_o, 32'h100);
        check_eq("ld_we",        32'(mem_bus.mem_we_o), 32'd0);
        check_eq("ld_rdata",     rdata, 32'hCAFEF00D);
        check_eq("ld_err",       32'(err), 32'd0);
        check_eq("ld_req_drop",  32'(mem_bus.mem_req_o), 32'd0);
        // Request still held during DONE must not relaunch
        tick();
        check_eq("ld_no_reissue", 32'(mem_bus.mem_req_o), 32'd0);
        mem_read = 1'b0;

        // Store, ack in 1st REQ cycle; ack data must not reach rdata
        tick();
        mem_write = 1'b1;
        addr      = 32'h24;
        wdata     = 32'h12345678;
        run_access(1, 32'hDEADBEEF, stalls, reqs);
        check_eq("st_stall_cyc", stalls, 2);
        check_eq("st_we",        32'(mem_bus.mem_we_o), 32'd1);
        check_eq("st_addr",      mem_bus.mem_addr_o, 32'h24);
        check_eq("st_wdata",     mem_bus.mem_wdata_o, 32'h12345678);
        check_eq("st_rdata",     rdata, 32'hCAFEF00D);
        tick();
        mem_write = 1'b0;

        // Misaligned load
        tick();
        mem_read = 1'b1;
        addr     = 32'h102;
        #1;
        check_eq("mis_stall", 32'(stall), 32'd0);
        tick();
        check_eq("mis_err",   32'(err), 32'd1);
        check_eq("mis_req",   32'(mem_bus.mem_req_o), 32'd0);
        check_eq("mis_stall_done", 32'(stall), 32'd0);
        mem_read = 1'b0;
        tick();
        check_eq("mis_err_clr", 32'(err), 32'd0);

        // Conflicting read+write
        mem_read  = 1'b1;
        mem_write = 1'b1;
        addr      = 32'h40;
        #1;
        check_eq("cfl_stall", 32'(stall), 32'd0);
        tick();
        check_eq("cfl_err",   32'(err), 32'd1);
        check_eq("cfl_req",   32'(mem_bus.mem_req_o), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();

        // Timeout: no ack
        mem_read = 1'b1;
        addr     = 32'h200;
        run_access(0, 32'h0, stalls, reqs);
        check_eq("to_req_cyc",   reqs, 16);
        check_eq("to_stall_cyc", stalls, 17);
        check_eq("to_err",       32'(err), 32'd1);
        check_eq("to_req_drop",  32'(mem_bus.mem_req_o), 32'd0);
        check_eq("to_rdata",     rdata, 32'hCAFEF00D);
        mem_read = 1'b0;
        tick();
        check_eq("to_err_clr", 32'(err), 32'd0);
        check_eq("to_idle",    32'(stall), 32'd0);

        // Back-to-back load then store
        rises0   = req_rises;
        mem_read = 1'b1;
        addr     = 32'h300;
        run_access(1, 32'h11112222, stalls, reqs);
        check_eq("b2b_ld_stall", stalls, 2);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b1;
        addr      = 32'h304;
        wdata     = 32'h55AA55AA;
        run_access(1, 32'h77777777, stalls, reqs);
        check_eq("b2b_st_stall", stalls, 2);
        tick();
        mem_write = 1'b0;
        tick();
        check_eq("b2b_req_count", req_rises - rises0, 2);
        check_eq("b2b_rdata",     rdata, 32'h11112222);

        // Reset two cycles into REQ, late ack ignored
        rises0   = req_rises;
        mem_read = 1'b1;
        addr     = 32'h400;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mem_read = 1'b0;
        #1;
        check_eq("rr_req",   32'(mem_bus.mem_req_o), 32'd0);
        check_eq("rr_rdata", rdata, 32'h0);
        mem_bus.mem_ack_i   = 1'b1;
        mem_bus.mem_rdata_i = 32'h99999999;
        tick();
        mem_bus.mem_ack_i = 1'b0;
        tick();
        check_eq("rr_ack_rdata", rdata, 32'h0);
        check_eq("rr_ack_req",   32'(mem_bus.mem_req_o), 32'd0);
        check_eq("rr_ack_err",   32'(err), 32'd0);
        check_eq("rr_launches",  req_rises - rises0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
